fetch_arbiter: RTL
==================

# fetch_arbiter

Shares the single instructionManager fetch port between up to NREQ requesters (decryption lanes, control sequencer) in the image-decryption core. Round-robin arbitration selects one pending request, the block issues its 8-bit address to the manager, waits for readyFlag with a timeout, and returns the 32-bit instruction to the granted requester as a one-cycle pulse. It sits between the lane fetch units and instructionManager. It is the only driver of the manager's parallelFlag and parallelAddress.

## Interface
- NREQ, 4: number of requesters, 2..8.
- AW, 8: address width. Matches parallelAddress.
- DW, 32: instruction width. Matches instructionOutput.
- TIMEOUT, 15: maximum WAIT cycles before an error response, 1..255.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NREQ  per-requester fetch request; held high until that requester's resp_valid.
- req_addr  in  NREQ*AW  packed addresses; slice i = req_addr[i*AW +: AW]; stable while req[i] is high.
- resp_valid  out  NREQ  one-hot, one-cycle response pulse.
- resp_data  out  DW  fetched instruction; valid only with resp_valid.
- resp_err  out  1  timeout flag; valid only with resp_valid.
- parallelFlag  out  1  fetch strobe to instructionManager.
- parallelAddress  out  AW  fetch address to instructionManager.
- readyFlag  in  1  manager data-ready.
- instructionOutput  in  DW  manager data.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, the picker selects index g.
  - g is the first set bit scanning from last+1 upward, wrapping at NREQ.
  - g and req_addr[g] are registered; next state is ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE, exactly one cycle:
  - parallelFlag = 1 and parallelAddress = latched address.
  - last <= g.
  - Next state is WAIT; wait counter is cleared to 0.
- WAIT: parallelFlag = 0. parallelAddress holds the latched address.
  - readyFlag = 1: capture instructionOutput, err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: data = 0, err = 1, go to RESP.
  - Otherwise increment the counter.
- RESP, exactly one cycle:
  - resp_valid[g] = 1, resp_data and resp_err driven from the captured values.
  - Next state is IDLE.
- Outputs outside RESP:
  - resp_valid = 0.
  - resp_data and resp_err hold their last values; receivers must not rely on them.
- readyFlag is ignored in IDLE, ISSUE and RESP. A late ready after a timeout is discarded.
- A requester that drops req mid-transaction:
  - The transaction still completes and the pulse is still issued.
  - The block has no abort path.
- The counter is 8 bits and saturates.

## Timing
- Reset (rst low, asynchronous) forces:
  - state = IDLE; last = NREQ-1, so req0 wins first.
  - g = 0; counter = 0.
  - parallelFlag = 0, parallelAddress = 0.
  - resp_valid = 0, resp_data = 0, resp_err = 0, busy = 0.
- Reset asserted mid-transaction abandons it; no response is produced.
- Fetch cycle numbering, with req sampled high in IDLE at edge 0:
  - ISSUE in cycle 1.
  - WAIT from cycle 2.
  - Ready seen in WAIT cycle k gives resp_valid in cycle k+1.
  - Minimum latency is 3 cycles from the req edge to resp_valid.
- Timeout response arrives in cycle 2+TIMEOUT.
- Back-to-back fetches:
  - The next arbitration happens in the IDLE cycle after RESP.
  - Minimum spacing is 4 cycles per fetch.
  - The responded requester sees resp_valid and must drop or re-raise req by that IDLE cycle; a still-high req is treated as a new request.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,2,3,0,…

## Structure
- Package fetch_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fetch_state_t.
  - Default constants FA_AW = 8, FA_DW = 32.
- Sub-module rr_picker (combinational, parameter NREQ):
  - Inputs: req vector, last index.
  - Outputs: grant index, any-request flag.
  - Instantiated once.
- All state lives in the fetch_arbiter top module.

## Test plan
- Reset behaviour: hold rst = 0 for 3 cycles with req = 4'b1111 -> all outputs 0 and busy = 0. After release, the first grant goes to req0.
- Single fetch: req[2] = 1, addr2 = 8'h3C; manager returns readyFlag in the 2nd WAIT cycle with 32'hDEADBEEF.
  - parallelFlag is high exactly one cycle with parallelAddress = 8'h3C.
  - resp_valid = 4'b0100, resp_data = 32'hDEADBEEF, resp_err = 0.
- Round-robin: req = 4'b1111 held, each with a distinct address, manager ready immediately -> grant order 0,1,2,3,0, each response 4 cycles apart.
- Timeout: req[1] = 1, readyFlag never asserted, TIMEOUT = 15.
  - resp_valid = 4'b0010 with resp_err = 1 and resp_data = 0, in cycle 17 after the req edge.
  - A readyFlag pulse afterwards is ignored.
- Reset mid-WAIT: assert rst = 0 during WAIT -> state returns to IDLE, no resp_valid pulse. A subsequent req[3] is served normally.
- Dropped request: req[0] falls during WAIT -> resp_valid[0] still pulses once, and the next IDLE grants the next pending index.

Source files
------------

// File: rtl/fetch_arb_pkg.sv
// Shared types and defaults for the instruction-fetch arbiter that fronts instructionManager.
package fetch_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } fetch_state_t;

  localparam int FA_AW    = 8;
  localparam int FA_DW    = 32;
  localparam int FA_CNT_W = 8;

  // Wait counter never wraps, so an oversized TIMEOUT cannot alias back to zero.
  function automatic logic [FA_CNT_W-1:0] satInc(input logic [FA_CNT_W-1:0] v);
    return (v == {FA_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_arbiter_if.sv
// Requester-side and manager-side signal bundle of the fetch arbiter.
interface fetch_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = fetch_arb_pkg::FA_AW,
  parameter int DW   = fetch_arb_pkg::FA_DW
);

  // Handshake: a requester raises req[i] with a stable req_addr slice and holds it until
  // resp_valid[i] pulses for one cycle; resp_data/resp_err are meaningful only in that cycle.
  // The arbiter pulses parallelFlag for one cycle with parallelAddress, then holds the address
  // until the manager raises readyFlag alongside instructionOutput, or the wait times out.
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic               resp_err;
  logic               parallelFlag;
  logic [AW-1:0]      parallelAddress;
  logic               readyFlag;
  logic [DW-1:0]      instructionOutput;
  logic               busy;

  modport master (
    input  req, req_addr, readyFlag, instructionOutput,
    output resp_valid, resp_data, resp_err, parallelFlag, parallelAddress, busy
  );

  modport slave (
    output req, req_addr, readyFlag, instructionOutput,
    input  resp_valid, resp_data, resp_err, parallelFlag, parallelAddress, busy
  );

endinterface

// File: rtl/fetch_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending request strictly after the last grant.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   grant,
  output logic            anyReq
);

  int   idx;
  logic found;

  // Offsets 1..NREQ put the last grant at the lowest priority.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        grant = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign anyReq = |req;

endmodule

// File: rtl/fetch_arbiter.sv
// Shares the instructionManager fetch port between NREQ requesters with round-robin grants,
// a bounded wait for readyFlag and a one-cycle response pulse to the granted requester.
module fetch_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = FA_AW,
  parameter int DW      = FA_DW,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_arbiter_if.master        bus,
  output fetch_state_t           dbgState
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  fetch_state_t          state;
  fetch_state_t          nextState;
  logic [IW-1:0]         lastIdx;
  logic [IW-1:0]         grantIdx;
  logic [IW-1:0]         pickIdx;
  logic                  anyReq;
  logic [AW-1:0]         latchedAddr;
  logic [FA_CNT_W-1:0]   waitCnt;
  logic [DW-1:0]         capData;
  logic                  capErr;
  logic                  timedOut;
  logic [NREQ-1:0]       respValid;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) uPicker (
    .req    (bus.req),
    .last   (lastIdx),
    .grant  (pickIdx),
    .anyReq (anyReq)
  );

  assign timedOut = (waitCnt == FA_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (bus.readyFlag || timedOut) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // readyFlag is only looked at in WAIT, so a late ready after a timeout falls on the floor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grantIdx    <= '0;
      lastIdx     <= IW'(NREQ - 1);
      latchedAddr <= '0;
      waitCnt     <= '0;
      capData     <= '0;
      capErr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantIdx    <= pickIdx;
            latchedAddr <= bus.req_addr[int'(pickIdx)*AW +: AW];
          end
        end
        ISSUE: begin
          lastIdx <= grantIdx;
          waitCnt <= '0;
        end
        WAIT: begin
          if (bus.readyFlag) begin
            capData <= bus.instructionOutput;
            capErr  <= 1'b0;
          end else if (timedOut) begin
            capData <= '0;
            capErr  <= 1'b1;
          end else begin
            waitCnt <= satInc(waitCnt);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    respValid = '0;
    if (state == RESP) respValid[grantIdx] = 1'b1;
  end

  assign bus.resp_valid      = respValid;
  assign bus.resp_data       = capData;
  assign bus.resp_err        = capErr;
  assign bus.parallelFlag    = (state == ISSUE);
  assign bus.parallelAddress = latchedAddr;
  assign bus.busy            = (state != IDLE);
  assign dbgState            = state;

endmodule
